// File: rtl/cache_mem_nway.sv
// N-way set-associative tag/data array with true-LRU ages, valid/dirty tracking and victim output.
// Optional macro FLUSH_EN adds flush_req and a write-back sweep of every dirty line.
module cache_mem_nway #(
    parameter  int unsigned WAYS   = 4,
    parameter  int unsigned SETS   = 64,
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned TAG_W  = 20,
    localparam int unsigned IDX_W  = $clog2(SETS),
    localparam int unsigned WAY_W  = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
`ifdef FLUSH_EN
    input  logic              flush_req,
`endif
    output logic              res_valid,
    output logic              res_hit,
    output logic [WAY_W-1:0]  res_way,
    output logic [DATA_W-1:0] res_data,
    output logic              evict_valid,
    output logic [TAG_W-1:0]  evict_tag,
    output logic [DATA_W-1:0] evict_data,
    output logic              init_busy
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE
`ifdef FLUSH_EN
        , ST_FLUSH
`endif
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] init_cnt;

    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS];
    logic              valid_mem [SETS][WAYS];
    logic              dirty_mem [SETS][WAYS];
    logic [WAY_W-1:0]  age_mem   [SETS][WAYS];

    logic             accept_c;
    logic             hit_c, inv_found_c, is_fill_c, is_write_c, upd_c, evict_c;
    logic [WAY_W-1:0] hit_way_c, inv_way_c, lru_way_c, acc_way_c, old_age_c;
    logic [WAY_W-1:0] new_age_c [WAYS];

`ifdef FLUSH_EN
    localparam int unsigned FL_W = IDX_W + WAY_W;
    logic [FL_W-1:0]  fl_cnt;
    logic [IDX_W-1:0] fl_set_c;
    logic [WAY_W-1:0] fl_way_c;
    assign fl_set_c = fl_cnt[FL_W-1:WAY_W];
    assign fl_way_c = fl_cnt[WAY_W-1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // Next-state and accept decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_INIT: if (init_cnt == IDX_W'(SETS - 1)) state_d = ST_IDLE;
            ST_IDLE: begin
                accept_c = req_valid;
`ifdef FLUSH_EN
                if (flush_req) begin
                    accept_c = 1'b0;
                    state_d  = ST_FLUSH;
                end
`endif
            end
`ifdef FLUSH_EN
            ST_FLUSH: if (fl_cnt == FL_W'(SETS * WAYS - 1)) state_d = ST_IDLE;
`endif
            default: state_d = ST_INIT;
        endcase
    end

    // Tag match, lowest invalid way and oldest way of the addressed set
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        lru_way_c   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_mem[req_idx][WAY_W'(w)] && (tag_mem[req_idx][WAY_W'(w)] == req_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_mem[req_idx][WAY_W'(w)] && !inv_found_c) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
            if (age_mem[req_idx][WAY_W'(w)] == WAY_W'(WAYS - 1)) lru_way_c = WAY_W'(w);
        end
    end

    // A fill that re-hits reuses the hit way; otherwise prefer an empty way over the LRU one
    always_comb begin
        is_fill_c  = (req_op == OP_FILL);
        is_write_c = (req_op == OP_WRITE);
        acc_way_c  = is_fill_c ? (hit_c ? hit_way_c : (inv_found_c ? inv_way_c : lru_way_c))
                               : hit_way_c;
        upd_c      = accept_c && (is_fill_c || hit_c);
        evict_c    = accept_c && is_fill_c && !hit_c && !inv_found_c
                     && dirty_mem[req_idx][lru_way_c];
        old_age_c  = age_mem[req_idx][acc_way_c];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way_c)
                new_age_c[w] = '0;
            else if (age_mem[req_idx][WAY_W'(w)] < old_age_c)
                new_age_c[w] = age_mem[req_idx][WAY_W'(w)] + WAY_W'(1);
            else
                new_age_c[w] = age_mem[req_idx][WAY_W'(w)];
        end
    end

    // Array storage; valid/dirty/ages are initialised by the INIT sweep rather than reset
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_mem[init_cnt][WAY_W'(w)] <= 1'b0;
                dirty_mem[init_cnt][WAY_W'(w)] <= 1'b0;
                age_mem[init_cnt][WAY_W'(w)]   <= WAY_W'(w);
            end
        end else if (upd_c) begin
            for (int unsigned w = 0; w < WAYS; w++)
                age_mem[req_idx][WAY_W'(w)] <= new_age_c[w];
            if (is_fill_c) begin
                tag_mem[req_idx][acc_way_c]   <= req_tag;
                data_mem[req_idx][acc_way_c]  <= req_data;
                valid_mem[req_idx][acc_way_c] <= 1'b1;
                dirty_mem[req_idx][acc_way_c] <= 1'b0;
            end else if (is_write_c) begin
                data_mem[req_idx][acc_way_c]  <= req_data;
                dirty_mem[req_idx][acc_way_c] <= 1'b1;
            end
        end
`ifdef FLUSH_EN
        else if (state_q == ST_FLUSH) begin
            valid_mem[fl_set_c][fl_way_c] <= 1'b0;
            dirty_mem[fl_set_c][fl_way_c] <= 1'b0;
        end
`endif
    end

    // Registered outputs and counters
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            init_cnt    <= '0;
            req_ready   <= 1'b0;
            init_busy   <= 1'b1;
            res_valid   <= 1'b0;
            res_hit     <= 1'b0;
            res_way     <= '0;
            res_data    <= '0;
            evict_valid <= 1'b0;
            evict_tag   <= '0;
            evict_data  <= '0;
`ifdef FLUSH_EN
            fl_cnt      <= '0;
`endif
        end else begin
            init_cnt    <= (state_q == ST_INIT) ? init_cnt + IDX_W'(1) : '0;
            req_ready   <= (state_d == ST_IDLE);
            init_busy   <= (state_d == ST_INIT);
            res_valid   <= accept_c;
            evict_valid <= evict_c;
            if (accept_c) begin
                res_hit  <= hit_c;
                res_way  <= acc_way_c;
                res_data <= (!is_fill_c && !is_write_c && hit_c) ? data_mem[req_idx][hit_way_c] : '0;
            end
            if (evict_c) begin
                evict_tag  <= tag_mem[req_idx][lru_way_c];
                evict_data <= data_mem[req_idx][lru_way_c];
            end
`ifdef FLUSH_EN
            fl_cnt <= (state_q == ST_FLUSH) ? fl_cnt + FL_W'(1) : '0;
            if ((state_q == ST_FLUSH) && valid_mem[fl_set_c][fl_way_c] && dirty_mem[fl_set_c][fl_way_c]) begin
                evict_valid <= 1'b1;
                evict_tag   <= tag_mem[fl_set_c][fl_way_c];
                evict_data  <= data_mem[fl_set_c][fl_way_c];
            end
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_nway.sv
// Self-checking bench for cache_mem_nway: directed test-plan steps plus random traffic against
// a recency-list reference model.
module tb_cache_mem_nway;

    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned WAY_W  = 2;

    localparam logic [1:0] OP_LOOK = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = '0;
    logic [IDX_W-1:0]  req_idx = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              res_valid, res_hit, evict_valid, init_busy;
    logic [WAY_W-1:0]  res_way;
    logic [DATA_W-1:0] res_data, evict_data;
    logic [TAG_W-1:0]  evict_tag;
`ifdef FLUSH_EN
    logic              flush_req = 1'b0;
`endif

    cache_mem_nway #(.WAYS(WAYS), .SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_tag(req_tag), .req_data(req_data),
`ifdef FLUSH_EN
        .flush_req(flush_req),
`endif
        .res_valid(res_valid), .res_hit(res_hit), .res_way(res_way), .res_data(res_data),
        .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_data(evict_data),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: line contents plus a per-set recency list, m_order[s][0] = most recent way
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [DATA_W-1:0] m_data  [SETS][WAYS];
    int                m_order [SETS][WAYS];
    bit                last_hit;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        last_hit = 1'b0;
    endtask

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic do_req(input logic [1:0] op, input int idx, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] data);
        bit hit, ev;
        int hw, vw;
        logic [TAG_W-1:0]  etag;
        logic [DATA_W-1:0] edata, exp_data;
        hit = 1'b0; hw = 0; ev = 1'b0; etag = '0; edata = '0; exp_data = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) begin hit = 1'b1; hw = w; end
        vw = hw;
        if (op == OP_FILL) begin
            if (!hit) begin
                vw = -1;
                for (int w = 0; w < WAYS; w++) if (!m_valid[idx][w] && vw < 0) vw = w;
                if (vw < 0) begin
                    vw    = m_order[idx][WAYS-1];
                    ev    = m_dirty[idx][vw];
                    etag  = m_tag[idx][vw];
                    edata = m_data[idx][vw];
                end
            end
            m_valid[idx][vw] = 1'b1;
            m_dirty[idx][vw] = 1'b0;
            m_tag[idx][vw]   = tag;
            m_data[idx][vw]  = data;
            touch(idx, vw);
        end else if (op == OP_WR) begin
            if (hit) begin
                m_data[idx][hw]  = data;
                m_dirty[idx][hw] = 1'b1;
                touch(idx, hw);
            end
        end else if (hit) begin
            exp_data = m_data[idx][hw];
            touch(idx, hw);
        end
        req_valid = 1'b1; req_op = op; req_idx = IDX_W'(idx); req_tag = tag; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("res_valid", 64'(res_valid), 64'(1));
        chk("res_hit", 64'(res_hit), 64'(hit));
        if (hit || op == OP_FILL) chk("res_way", 64'(res_way), 64'(vw));
        chk("res_data", res_data, exp_data);
        chk("evict_valid", 64'(evict_valid), 64'(ev));
        if (ev) begin
            chk("evict_tag", 64'(evict_tag), 64'(etag));
            chk("evict_data", evict_data, edata);
        end
        last_hit = hit;
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        chk("res_valid_pulse", 64'(res_valid), 64'(0));
        chk("res_hit_hold", 64'(res_hit), 64'(last_hit));
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        chk("init_busy_start", 64'(init_busy), 64'(1));
        while (!req_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("init_cycles", 64'(cnt), 64'(SETS));
        chk("init_busy_done", 64'(init_busy), 64'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] d [4];
        logic [DATA_W-1:0] x;

        model_reset();
        #23;
        chk("rst_init_busy", 64'(init_busy), 64'(1));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_data", res_data, 64'(0));
        chk("rst_evict_valid", 64'(evict_valid), 64'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;
        wait_init();

        do_req(OP_LOOK, 5, 20'h123, '0);
        chk("tp_first_miss", 64'(res_hit), 64'(0));

        for (int i = 0; i < 4; i++) begin
            d[i] = {$urandom(), $urandom()};
            do_req(OP_FILL, 3, TAG_W'(32'hA + 32'(i)), d[i]);
            chk("tp_fill_order", 64'(res_way), 64'(i));
        end
        do_req(OP_LOOK, 3, 20'hB, '0);
        chk("tp_lookup_way", 64'(res_way), 64'(1));
        chk("tp_lookup_data", res_data, d[1]);
        idle_chk();

        for (int i = 0; i < 4; i++) do_req(OP_FILL, 4, TAG_W'(32'hA + 32'(i)), {$urandom(), $urandom()});
        do_req(OP_LOOK, 4, 20'hA, '0);
        do_req(OP_FILL, 4, 20'hE, {$urandom(), $urandom()});
        chk("tp_lru_victim", 64'(res_way), 64'(1));
        chk("tp_clean_no_evict", 64'(evict_valid), 64'(0));

        do_req(OP_WR, 4, 20'hC, 64'hDEADBEEF);
        do_req(OP_LOOK, 4, 20'hA, '0);
        do_req(OP_LOOK, 4, 20'hD, '0);
        do_req(OP_LOOK, 4, 20'hE, '0);
        do_req(OP_FILL, 4, 20'hF, {$urandom(), $urandom()});
        chk("tp_dirty_evict", 64'(evict_valid), 64'(1));
        chk("tp_evict_tag", 64'(evict_tag), 64'h0C);
        chk("tp_evict_data", evict_data, 64'hDEADBEEF);
        idle_chk();

        x = {$urandom(), $urandom()};
        do_req(OP_FILL, 9, 20'h7, x);
        do_req(OP_LOOK, 9, 20'h7, '0);
        chk("tp_b2b_hit", 64'(res_hit), 64'(1));
        chk("tp_b2b_data", res_data, x);

        // Reset in the middle of an accept: response dropped, sweep restarts
        req_valid = 1'b1; req_op = OP_LOOK; req_idx = IDX_W'(3); req_tag = 20'hB;
        #4 n_rst = 1'b0;
        #2;
        req_valid = 1'b0;
        chk("midrst_res_valid", 64'(res_valid), 64'(0));
        chk("midrst_init_busy", 64'(init_busy), 64'(1));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;
        model_reset();
        wait_init();
        do_req(OP_LOOK, 3, 20'hB, '0);
        chk("midrst_cleared", 64'(res_hit), 64'(0));

        for (int n = 0; n < 400; n++) begin
            do_req(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   TAG_W'($urandom_range(0, 9)), {$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) idle_chk();
        end

`ifdef FLUSH_EN
        begin
            int pulses, cyc, rv;
            logic [DATA_W-1:0] fd;
            n_rst = 1'b0;
            #3;
            @(posedge clk); #1;
            n_rst = 1'b1;
            model_reset();
            wait_init();
            fd = {$urandom(), $urandom()};
            for (int s = 10; s < 13; s++) begin
                do_req(OP_FILL, s, 20'h1, '0);
                do_req(OP_WR, s, 20'h1, (s == 10) ? fd : {$urandom(), $urandom()});
            end
            do_req(OP_FILL, 13, 20'h2, {$urandom(), $urandom()});
            flush_req = 1'b1;
            @(posedge clk); #1;
            flush_req = 1'b0;
            chk("flush_ready_low", 64'(req_ready), 64'(0));
            pulses = 0; cyc = 0; rv = 0;
            while (!req_ready && cyc < 400) begin
                if (evict_valid) begin
                    if (pulses == 0) begin
                        chk("flush_first_tag", 64'(evict_tag), 64'h1);
                        chk("flush_first_data", evict_data, fd);
                    end
                    pulses++;
                end
                if (res_valid) rv++;
                @(posedge clk); #1;
                cyc++;
            end
            if (evict_valid) pulses++;
            chk("flush_pulses", 64'(pulses), 64'(3));
            chk("flush_res_quiet", 64'(rv), 64'(0));
            chk("flush_ready_back", 64'(req_ready), 64'(1));
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    m_valid[s][w] = 1'b0;
                    m_dirty[s][w] = 1'b0;
                end
            for (int s = 10; s < 13; s++) do_req(OP_LOOK, s, 20'h1, '0);
            do_req(OP_LOOK, 13, 20'h2, '0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_nway.md
Name: cache_mem_nway

Overview:
Parametrised N-way set-associative tag/data store with true-LRU replacement, valid and dirty tracking, and a victim/eviction output.
- Next-generation cache memory array, sitting between the cache controller FSM and the per-way storage.
- Single-cycle request acceptance and registered one-cycle response.
- Hardware invalidate sweep after reset.

Parameters:
WAYS, 4, number of ways (power of two, 2..8)
SETS, 64, number of sets (power of two)
DATA_W, 64, line data width in bits
TAG_W, 20, tag width in bits
IDX_W, $clog2(SETS), derived index width (localparam)
WAY_W, $clog2(WAYS), derived way-select width (localparam)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  high when a request can be accepted
req_op  in  2  00 lookup, 01 write-hit, 10 fill, 11 reserved (treated as lookup)
req_idx  in  IDX_W  set index
req_tag  in  TAG_W  tag
req_data  in  DATA_W  write/fill data
res_valid  out  1  response strobe, one cycle after accept
res_hit  out  1  tag matched a valid way
res_way  out  WAY_W  hit way (lookup, write-hit) or filled way (fill)
res_data  out  DATA_W  hit data (lookup); 0 otherwise
evict_valid  out  1  fill displaced a valid dirty line; qualified by res_valid
evict_tag  out  TAG_W  displaced tag
evict_data  out  DATA_W  displaced data
init_busy  out  1  invalidate sweep in progress

Behaviour:
- Reset (n_rst low, async):
  - All outputs 0 except init_busy=1.
  - FSM enters INIT with sweep counter 0.
- FSM states:
  - INIT: each cycle clear valid, dirty and LRU ages of set[counter]. LRU ages are reset to way index, so way 0 is MRU and way WAYS-1 is LRU. Increment counter. After set SETS-1 go to IDLE. Takes exactly SETS cycles. req_ready=0 throughout.
  - IDLE: req_ready=1. Accept occurs when req_valid && req_ready. No stalls; back-to-back accepts are allowed every cycle.
  - FLUSH: only when FLUSH_EN is defined.
- Lookup:
  - Compare req_tag against all valid ways of the set. At most one match is guaranteed by construction.
  - Next cycle: res_valid=1, res_hit, res_way, res_data.
  - On hit, the hit way becomes MRU. A miss leaves state unchanged.
- Write-hit:
  - On hit, overwrite data, set dirty, and make the way MRU.
  - On miss, no state change and res_hit=0.
- Fill:
  - Victim is the lowest-index invalid way; otherwise the way with the oldest age (age WAYS-1).
  - Write tag and data, set valid, clear dirty, make the way MRU.
  - If the victim was valid and dirty, evict_valid=1 with its old tag and data, in the same cycle as res_valid.
  - If req_tag already hits, overwrite that way instead (no eviction) and return res_hit=1.
- LRU update, per set, WAY_W-bit age per way:
  - The accessed way's age goes to 0.
  - Ways with age less than its old age increment by 1.
  - All other ways are unchanged.
  - Ages stay a permutation of 0..WAYS-1.
- Same-set consecutive requests: the second request observes the first one's updates (write-before-read ordering); no stale hit or victim.
- Responses are registered. res_valid is a one-cycle pulse per accept. res_* holds its value until the next accept.
- n_rst asserted mid-operation: any in-flight response is dropped and the block re-enters INIT.

Optional Feature:
FLUSH_EN
- Defined:
  - Adds input flush_req (1 bit).
  - Sampled high in IDLE, it enters FLUSH, with req_ready=0.
  - FLUSH walks every (set, way) in set-major order, one per cycle (SETS*WAYS cycles).
  - For each valid dirty line it pulses evict_valid with that line's tag and data; res_valid stays 0.
  - Clears valid and dirty, then returns to IDLE.
  - A flush_req arriving in the same cycle as a request takes priority; the request is not accepted.
- Undefined: no flush_req port and no FLUSH state. The evict port is driven only by fills.

Test Plan:
- Reset with SETS=64 -> init_busy=1 and req_ready=0 for exactly 64 cycles, then req_ready=1; a lookup of idx 5, tag 0x123 returns res_hit=0.
- Fill idx 3 with tags 0xA,0xB,0xC,0xD -> ways 0,1,2,3 in order; a lookup of 0xB returns res_hit=1, res_way=1, and the filled data.
- After the fills above, lookup 0xA, then fill 0xE -> victim is way 1 (tag 0xB, the LRU); evict_valid=0 because the line is clean.
- Write-hit 0xC with data 0xDEADBEEF, touch all other ways, then fill 0xF -> evict_valid=1, evict_tag=0xC, evict_data=0xDEADBEEF.
- Back-to-back fill 0x7 then lookup 0x7 on idx 9 in consecutive cycles -> second response res_hit=1, and the data matches.
- FLUSH_EN defined with 3 dirty lines -> exactly 3 evict_valid pulses over 256 cycles; all subsequent lookups miss.
